// File: rtl/alu_pkg.sv
// Shared opcodes and controller state encoding for the ALU sharing controller.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;
    localparam logic [3:0] ALU_NOP = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the port at ptr.
module alu_rr_pick (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates one combinational ALU between two requesters, holding operands
// for multi-cycle multiplies and returning a registered result per owner.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int DW         = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req0Valid,
    output logic                 Req0Ready,
    input  logic [3:0]           Req0Ctrl,
    input  logic signed [DW-1:0] Req0A,
    input  logic signed [DW-1:0] Req0B,
    input  logic                 Req1Valid,
    output logic                 Req1Ready,
    input  logic [3:0]           Req1Ctrl,
    input  logic signed [DW-1:0] Req1A,
    input  logic signed [DW-1:0] Req1B,
    output logic                 Resp0Valid,
    input  logic                 Resp0Ready,
    output logic                 Resp1Valid,
    input  logic                 Resp1Ready,
    output logic signed [DW-1:0] RespResult,
    output logic                 RespZero,
    output logic [3:0]           AluControl,
    output logic signed [DW-1:0] AluA,
    output logic signed [DW-1:0] AluB,
    input  logic signed [DW-1:0] AluResult
);

    localparam int              CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

    // Unknown opcodes collapse to a nop so the ALU never sees an undefined code.
    function automatic logic [3:0] legal_ctrl(input logic [3:0] ctrl);
        return (ctrl > ALU_NOP) ? ALU_NOP : ctrl;
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic                 rr_ptr;
    logic                 owner;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           cap_ctrl;
    logic signed [DW-1:0] cap_a;
    logic signed [DW-1:0] cap_b;
    logic signed [DW-1:0] resp_result;

    logic [1:0]           pick;
    logic                 win;
    logic [3:0]           sel_ctrl;
    logic signed [DW-1:0] sel_a;
    logic signed [DW-1:0] sel_b;
    logic                 grant_fire;
    logic                 exec_last;
    logic                 resp_fire;

    alu_rr_pick u_pick (
        .valid0 (Req0Valid),
        .valid1 (Req1Valid),
        .ptr    (rr_ptr),
        .grant  (pick)
    );

    always_comb begin
        win      = pick[1];
        sel_ctrl = legal_ctrl(win ? Req1Ctrl : Req0Ctrl);
        sel_a    = win ? Req1A : Req0A;
        sel_b    = win ? Req1B : Req0B;
    end

    // Ready is gated by Reset so nothing is accepted while reset is held.
    always_comb begin
        state_nxt  = state;
        Req0Ready  = 1'b0;
        Req1Ready  = 1'b0;
        Resp0Valid = 1'b0;
        Resp1Valid = 1'b0;
        AluControl = ALU_NOP;
        AluA       = '0;
        AluB       = '0;
        grant_fire = 1'b0;
        exec_last  = 1'b0;
        resp_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!Reset && (pick != 2'b00)) begin
                    Req0Ready  = pick[0];
                    Req1Ready  = pick[1];
                    grant_fire = 1'b1;
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                AluControl = cap_ctrl;
                AluA       = cap_a;
                AluB       = cap_b;
                if (cnt == '0) begin
                    exec_last = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                Resp0Valid = !owner;
                Resp1Valid = owner;
                resp_fire  = owner ? Resp1Ready : Resp0Ready;
                if (resp_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            cnt         <= '0;
            resp_result <= '0;
        end else begin
            state <= state_nxt;
            if (grant_fire) begin
                rr_ptr <= ~win;
                owner  <= win;
                cnt    <= (sel_ctrl == ALU_MUL) ? MUL_LAST : '0;
            end else if ((state == ST_EXEC) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (exec_last) begin
                resp_result <= AluResult;
            end
        end
    end

    // Operand capture: only read in EXEC, which always follows a grant.
    always_ff @(posedge Clk) begin
        if (grant_fire) begin
            cap_ctrl <= sel_ctrl;
            cap_a    <= sel_a;
            cap_b    <= sel_b;
        end
    end

    assign RespResult = resp_result;
    assign RespZero   = (resp_result == '0);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, latency and results.
module tb_alu_share_ctrl;

    localparam int MULC = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req0Valid = 1'b0, Req1Valid = 1'b0;
    logic        Req0Ready, Req1Ready;
    logic [3:0]  Req0Ctrl = '0, Req1Ctrl = '0;
    logic [31:0] Req0A = '0, Req0B = '0, Req1A = '0, Req1B = '0;
    logic        Resp0Valid, Resp1Valid;
    logic        Resp0Ready = 1'b0, Resp1Ready = 1'b0;
    logic [31:0] RespResult;
    logic        RespZero;
    logic [3:0]  AluControl;
    logic [31:0] AluA, AluB, AluResult;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state, timestamp based: an op is pending from grant until its response handshake.
    int          cyc = 0;
    bit          m_pend = 0;
    int          m_due = 0;
    bit          m_owner = 0;
    bit          m_ptr = 0;
    logic [3:0]  m_ctrl = 4'd10;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0, m_last = '0;
    bit          acc0 = 0, acc1 = 0;

    alu_share_ctrl #(.MUL_CYCLES(MULC), .DW(32)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req0Valid  (Req0Valid),
        .Req0Ready  (Req0Ready),
        .Req0Ctrl   (Req0Ctrl),
        .Req0A      (Req0A),
        .Req0B      (Req0B),
        .Req1Valid  (Req1Valid),
        .Req1Ready  (Req1Ready),
        .Req1Ctrl   (Req1Ctrl),
        .Req1A      (Req1A),
        .Req1B      (Req1B),
        .Resp0Valid (Resp0Valid),
        .Resp0Ready (Resp0Ready),
        .Resp1Valid (Resp1Valid),
        .Resp1Ready (Resp1Ready),
        .RespResult (RespResult),
        .RespZero   (RespZero),
        .AluControl (AluControl),
        .AluA       (AluA),
        .AluB       (AluB),
        .AluResult  (AluResult)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return ~(a | b);
            4'd6:    return a ^ b;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always_comb AluResult = alu_ref(AluControl, AluA, AluB);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare every DUT output for the current cycle, then advance the model by one clock.
    task automatic step();
        bit          ex, rs, g0, g1;
        logic [3:0]  c;
        logic [31:0] e_ctrl, e_a, e_b;
        if (Reset) begin
            chk("req0_ready", Req0Ready, 0);
            chk("req1_ready", Req1Ready, 0);
            chk("resp0_valid", Resp0Valid, 0);
            chk("resp1_valid", Resp1Valid, 0);
            chk("resp_result", RespResult, 0);
            chk("resp_zero", RespZero, 1);
            chk("alu_ctrl", AluControl, 10);
            chk("alu_a", AluA, 0);
            chk("alu_b", AluB, 0);
            m_pend = 0;
            m_ptr  = 0;
            m_last = '0;
            acc0   = 0;
            acc1   = 0;
        end else begin
            ex = m_pend && (cyc < m_due);
            rs = m_pend && (cyc >= m_due);
            g0 = !m_pend && Req0Valid && (!Req1Valid || !m_ptr);
            g1 = !m_pend && Req1Valid && (!Req0Valid || m_ptr);
            e_ctrl = ex ? {28'd0, m_ctrl} : 32'd10;
            e_a    = ex ? m_a : 32'd0;
            e_b    = ex ? m_b : 32'd0;
            chk("req0_ready", Req0Ready, g0);
            chk("req1_ready", Req1Ready, g1);
            chk("resp0_valid", Resp0Valid, rs && !m_owner);
            chk("resp1_valid", Resp1Valid, rs && m_owner);
            chk("resp_result", RespResult, m_last);
            chk("resp_zero", RespZero, m_last == 0);
            chk("alu_ctrl", AluControl, e_ctrl);
            chk("alu_a", AluA, e_a);
            chk("alu_b", AluB, e_b);
            acc0 = g0;
            acc1 = g1;
            if (ex && (cyc == m_due - 1)) m_last = m_res;
            if (rs && (m_owner ? Resp1Ready : Resp0Ready)) m_pend = 0;
            if (g0 || g1) begin
                c = g1 ? Req1Ctrl : Req0Ctrl;
                if (c > 4'd10) c = 4'd10;
                m_pend  = 1;
                m_owner = g1;
                m_ptr   = !g1;
                m_ctrl  = c;
                m_a     = g1 ? Req1A : Req0A;
                m_b     = g1 ? Req1B : Req0B;
                m_res   = alu_ref(c, m_a, m_b);
                m_due   = cyc + 1 + ((c == 4'd2) ? MULC : 1);
            end
        end
        cyc++;
    endtask

    task automatic cycle();
        #1;
        step();
    endtask

    task automatic adv();
        @(negedge Clk);
    endtask

    task automatic set_req(input int port, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            Req0Valid = 1'b1; Req0Ctrl = c; Req0A = a; Req0B = b;
        end else begin
            Req1Valid = 1'b1; Req1Ctrl = c; Req1A = a; Req1B = b;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        Resp0Ready = 1'b0; Resp1Ready = 1'b0;
        cycle();
        adv();
        Reset = 1'b0;
    endtask

    // One isolated op: grant, bounded wait for the response, then handshake a cycle later.
    task automatic single_op(input string nm, input int port, input logic [3:0] c,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input int exp_lat);
        int lat;
        set_req(port, c, a, b);
        cycle();
        chk({nm, "_grant"}, (port == 0) ? Req0Ready : Req1Ready, 1);
        adv();
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        lat = 1;
        cycle();
        while (!((port == 0) ? Resp0Valid : Resp1Valid) && lat < 20) begin
            adv();
            cycle();
            lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_result"}, RespResult, exp_res);
        chk({nm, "_zero"}, RespZero, exp_res == 0);
        adv();
        if (port == 0) Resp0Ready = 1'b1; else Resp1Ready = 1'b1;
        cycle();
        adv();
        Resp0Ready = 1'b0; Resp1Ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit hold0, hold1;
        adv();
        do_reset();

        // add alone
        single_op("add", 0, 4'd0, 32'd5, 32'd7, 32'd12, 2);

        // ties after reset: port 0, then port 1, then port 0 again
        do_reset();
        set_req(0, 4'd1, 32'd9, 32'd9);
        set_req(1, 4'd4, 32'd1, 32'd2);
        cycle();
        chk("tie1_r0", Req0Ready, 1);
        chk("tie1_r1", Req1Ready, 0);
        adv(); Req0Valid = 1'b0;
        cycle();
        chk("tie1_exec_r1", Req1Ready, 0);
        adv();
        cycle();
        chk("sub_valid", Resp0Valid, 1);
        chk("sub_result", RespResult, 0);
        chk("sub_zero", RespZero, 1);
        adv(); Resp0Ready = 1'b1;
        cycle();
        adv(); Resp0Ready = 1'b0;
        set_req(0, 4'd0, 32'd1, 32'd1);
        cycle();
        chk("tie2_r1", Req1Ready, 1);
        chk("tie2_r0", Req0Ready, 0);
        adv(); Req1Valid = 1'b0;
        cycle();
        adv();
        cycle();
        chk("or_valid", Resp1Valid, 1);
        chk("or_result", RespResult, 3);
        adv(); Resp1Ready = 1'b1;
        cycle();
        adv(); Resp1Ready = 1'b0;
        set_req(1, 4'd6, 32'd6, 32'd3);
        cycle();
        chk("tie3_r0", Req0Ready, 1);
        chk("tie3_r1", Req1Ready, 0);
        adv(); Req0Valid = 1'b0;
        cycle();
        adv();
        cycle();
        chk("add11_result", RespResult, 2);
        adv(); Resp0Ready = 1'b1;
        cycle();
        adv(); Resp0Ready = 1'b0;
        cycle();
        chk("xor_grant", Req1Ready, 1);
        adv(); Req1Valid = 1'b0;
        cycle();
        adv();
        cycle();
        chk("xor_result", RespResult, 5);
        adv(); Resp1Ready = 1'b1;
        cycle();
        adv(); Resp1Ready = 1'b0;

        // multi-cycle mul on port 1
        do_reset();
        single_op("mul", 1, 4'd2, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFF4, MULC + 1);

        // response backpressure blocks the next grant
        do_reset();
        set_req(0, 4'd0, 32'd2, 32'd3);
        cycle();
        chk("bp_grant0", Req0Ready, 1);
        adv(); Req0Valid = 1'b0;
        set_req(1, 4'd1, 32'd10, 32'd4);
        cycle();
        chk("bp_exec_r1", Req1Ready, 0);
        adv();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_hold_valid", Resp0Valid, 1);
            chk("bp_hold_result", RespResult, 5);
            chk("bp_hold_r1", Req1Ready, 0);
            adv();
        end
        Resp0Ready = 1'b1;
        cycle();
        chk("bp_handshake_r1", Req1Ready, 0);
        adv(); Resp0Ready = 1'b0;
        cycle();
        chk("bp_grant1", Req1Ready, 1);
        adv(); Req1Valid = 1'b0;
        cycle();
        adv();
        cycle();
        chk("bp_sub_result", RespResult, 6);
        adv(); Resp1Ready = 1'b1;
        cycle();
        adv(); Resp1Ready = 1'b0;

        // reset during a mul aborts it silently
        do_reset();
        set_req(0, 4'd2, 32'd7, 32'd7);
        cycle();
        chk("abort_grant", Req0Ready, 1);
        adv(); Req0Valid = 1'b0;
        cycle();
        chk("abort_exec_ctrl", AluControl, 2);
        adv();
        Reset = 1'b1;
        cycle();
        chk("abort_rst_ctrl", AluControl, 10);
        chk("abort_rst_result", RespResult, 0);
        chk("abort_rst_zero", RespZero, 1);
        adv(); Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("abort_no_resp", Resp0Valid, 0);
            adv();
        end
        single_op("slt", 0, 4'd9, 32'd2, 32'd3, 32'd1, 2);

        // illegal opcode becomes nop
        set_req(0, 4'd13, 32'd1, 32'd1);
        cycle();
        adv(); Req0Valid = 1'b0;
        cycle();
        chk("illegal_alu_ctrl", AluControl, 10);
        adv();
        cycle();
        chk("illegal_valid", Resp0Valid, 1);
        chk("illegal_result", RespResult, 0);
        chk("illegal_zero", RespZero, 1);
        adv(); Resp0Ready = 1'b1;
        cycle();
        adv(); Resp0Ready = 1'b0;

        // randomized traffic, requests held until accepted
        hold0 = 0; hold1 = 0;
        acc0 = 0; acc1 = 0;
        for (int i = 0; i < 4000; i++) begin
            if (acc0) begin hold0 = 0; Req0Valid = 1'b0; end
            if (acc1) begin hold1 = 0; Req1Valid = 1'b0; end
            if (!hold0 && $urandom_range(0, 2) == 0) begin
                hold0 = 1;
                set_req(0, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10,
                        $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10);
            end
            if (!hold1 && $urandom_range(0, 2) == 0) begin
                hold1 = 1;
                set_req(1, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10,
                        $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10);
            end
            Resp0Ready = 1'($urandom_range(0, 1));
            Resp1Ready = 1'($urandom_range(0, 1));
            Reset = ($urandom_range(0, 299) == 0);
            cycle();
            adv();
        end
        Reset = 1'b0;
        Req0Valid = 1'b0; Req1Valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
